siso_tx_scheduler: RTL and testbench

- Two-requester scheduler for a shared WIDTH-bit serial-out shift register.
- Arbitrates requests round-robin, loads the winner's parallel word into the register, then clocks it out MSB-first one bit per cycle.
- Signals completion with a one-cycle done pulse.
- Sits between parallel producers and the single-wire serial chain built from the team's D flip-flop shift stages.

---
 rtl/siso_ctrl_pkg.sv | 9 +
 rtl/flip_flop.sv | 10 +
 rtl/piso_shift_reg.sv | 21 ++
 rtl/siso_tx_scheduler.sv | 67 ++++++
 tb/tb_siso_tx_scheduler.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/siso_ctrl_pkg.sv
// siso_ctrl_pkg: shared FSM encodings and default transfer width for the serial TX scheduler.
package siso_ctrl_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/flip_flop.sv
// flip_flop: single D flip-flop stage with synchronous active-high reset.
module flip_flop (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk)
    q <= rst ? 1'b0 : d;
endmodule

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-load, left-shift register built from flip_flop stages; load beats shift.
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] pdin,
  output logic             sout
);
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] d;
  assign nxt = {q[WIDTH-2:0], 1'b0};
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    assign d[i] = load ? pdin[i] : shift ? nxt[i] : q[i];
    flip_flop u_ff (.clk(clk), .rst(rst), .d(d[i]), .q(q[i]));
  end
  assign sout = q[WIDTH-1];
endmodule

// File: rtl/siso_tx_scheduler.sv
// siso_tx_scheduler: round-robin arbiter for two requesters feeding one MSB-first serial shift register.
module siso_tx_scheduler
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic [1:0]       gnt,
  output logic             owner,
  output logic             busy,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] gnt_q, gnt_d;
  logic owner_q, owner_d, ptr_q, ptr_d;
  logic capture, last, winner, sr_out;
  assign capture = (state_q == ST_IDLE) && (|req);
  assign last    = cnt_q == CW'(WIDTH - 1);
  // Contention goes to the pointer; a lone request always wins.
  assign winner  = (req == 2'b11) ? ptr_q : req[1];
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  always_comb begin
    state_d = (state_q == ST_IDLE)  ? (capture ? ST_SHIFT : ST_IDLE) :
              (state_q == ST_SHIFT) ? (last ? ST_DONE : ST_SHIFT) : ST_IDLE;
    cnt_d   = capture ? '0 : (state_q == ST_SHIFT && !last) ? cnt_q + 1'b1 : cnt_q;
    gnt_d   = capture ? (winner ? 2'b10 : 2'b01) : 2'b00;
    owner_d = capture ? winner : owner_q;
    ptr_d   = (state_q == ST_DONE) ? ~owner_q : ptr_q;
  end
  always_comb begin
    busy       = state_q != ST_IDLE;
    sout_valid = state_q == ST_SHIFT;
    sout       = sout_valid & sr_out;
    done       = state_q == ST_DONE;
    gnt        = gnt_q;
    owner      = owner_q;
  end
  piso_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk  (clk),
    .rst  (rst),
    .load (capture),
    .shift(state_q == ST_SHIFT),
    .pdin (winner ? din1 : din0),
    .sout (sr_out)
  );
endmodule

// File: tb/tb_siso_tx_scheduler.sv
// tb_siso_tx_scheduler: directed checks of arbitration, serialization, reset and drop behaviour at WIDTH 4 and 8.
module tb_siso_tx_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [3:0] din0 = '0, din1 = '0;
  logic [1:0] gnt;
  logic owner, busy, sout, sout_valid, done;
  logic [1:0] req8 = 2'b00;
  logic [7:0] din0_8 = '0, din1_8 = '0;
  logic [1:0] gnt8;
  logic owner8, busy8, sout8, sv8, done8;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  siso_tx_scheduler #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .req(req), .din0(din0), .din1(din1), .gnt(gnt), .owner(owner),
    .busy(busy), .sout(sout), .sout_valid(sout_valid), .done(done)
  );
  siso_tx_scheduler #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .req(req8), .din0(din0_8), .din1(din1_8), .gnt(gnt8), .owner(owner8),
    .busy(busy8), .sout(sout8), .sout_valid(sv8), .done(done8)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Called in an IDLE cycle with req already driven; r1/r2 are the req values applied in E+1 and E+2.
  task automatic xfer(input string tag, input logic [1:0] g, input logic o, input logic [3:0] w,
                      input logic [1:0] r1, input logic [1:0] r2);
    tick;
    chk({tag, " gnt"}, gnt, g);
    chk({tag, " owner"}, owner, o);
    for (int i = 3; i >= 0; i--) begin
      chk($sformatf("%s bit%0d", tag, i), sout, w[i]);
      chk($sformatf("%s sv%0d", tag, i), sout_valid, 1);
      chk($sformatf("%s busy%0d", tag, i), busy, 1);
      if (i < 3) chk($sformatf("%s nognt%0d", tag, i), gnt, 0);
      if (i == 3) req = r1;
      if (i == 2) req = r2;
      tick;
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " done busy"}, busy, 1);
    chk({tag, " done sv"}, sout_valid, 0);
    chk({tag, " done sout"}, sout, 0);
    chk({tag, " done gnt"}, gnt, 0);
    tick;
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle done"}, done, 0);
    chk({tag, " idle gnt"}, gnt, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] bits;
    int nv, done_at;
    tick;
    tick;
    chk("rst gnt", gnt, 0);
    chk("rst owner", owner, 0);
    chk("rst busy", busy, 0);
    chk("rst sout", sout, 0);
    chk("rst sv", sout_valid, 0);
    chk("rst done", done, 0);
    rst = 1'b0;
    req = 2'b01;
    din0 = 4'b1011;
    xfer("single", 2'b01, 1'b0, 4'b1011, 2'b00, 2'b00);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req = 2'b11;
    din0 = 4'hA;
    din1 = 4'h5;
    xfer("both1", 2'b01, 1'b0, 4'hA, 2'b11, 2'b11);
    xfer("both2", 2'b10, 1'b1, 4'h5, 2'b11, 2'b11);
    xfer("both3", 2'b01, 1'b0, 4'hA, 2'b00, 2'b00);
    req = 2'b01;
    din0 = 4'b1100;
    din1 = 4'b0110;
    xfer("busyreq0", 2'b01, 1'b0, 4'b1100, 2'b00, 2'b10);
    xfer("busyreq1", 2'b10, 1'b1, 4'b0110, 2'b00, 2'b00);
    req = 2'b01;
    din0 = 4'b1001;
    xfer("pre_abort", 2'b01, 1'b0, 4'b1001, 2'b00, 2'b00);
    req = 2'b10;
    tick;
    chk("abort gnt", gnt, 2'b10);
    req = 2'b00;
    tick;
    tick;
    chk("abort shift3 sv", sout_valid, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort gnt0", gnt, 0);
    chk("abort owner0", owner, 0);
    chk("abort busy0", busy, 0);
    chk("abort sv0", sout_valid, 0);
    chk("abort sout0", sout, 0);
    chk("abort done0", done, 0);
    tick;
    chk("abort no done", done, 0);
    req = 2'b11;
    din0 = 4'b0111;
    din1 = 4'b1110;
    xfer("post_abort", 2'b01, 1'b0, 4'b0111, 2'b00, 2'b00);
    req = 2'b01;
    #1 req = 2'b00;
    tick;
    chk("drop gnt", gnt, 0);
    chk("drop busy", busy, 0);
    chk("drop sv", sout_valid, 0);
    tick;
    chk("drop still idle", busy, 0);
    req8 = 2'b10;
    din1_8 = 8'hC3;
    bits = '0;
    nv = 0;
    done_at = 0;
    tick;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin
        chk("w8 gnt", gnt8, 2'b10);
        chk("w8 owner", owner8, 1);
        req8 = 2'b00;
      end
      if (sv8) begin
        bits = {bits[6:0], sout8};
        nv++;
      end
      if (done8 && done_at == 0) done_at = k;
      tick;
    end
    chk("w8 bits", bits, 8'hC3);
    chk("w8 nvalid", nv, 8);
    chk("w8 done cycle", done_at, 9);
    chk("w8 idle", busy8, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
